// File: rtl/pcie_scr_pkg.sv
// +----------------------------------------------------------------------------+
// | pcie_scr_pkg: constants and LFSR helper for the Gen1/Gen2 TX scrambler    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package pcie_scr_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [7:0]  K_COM     = 8'hBC;
    localparam logic [7:0]  K_SKP     = 8'h1C;

    typedef struct packed {
        logic [15:0] state;
        logic [7:0]  key;
    } lfsr_step_t;

    // X^16+X^5+X^4+X^3+1, key bit i is S[15] before step i (LSB first)
    function automatic lfsr_step_t lfsr16_step8(input logic [15:0] state);
        lfsr_step_t r;
        logic [15:0] s;
        logic        fb;
        s = state;
        r.key = '0;
        for (int i = 0; i < 8; i++) begin
            fb       = s[15];
            r.key[i] = fb;
            s        = {s[14:0], fb};
            s[3]     = s[3] ^ fb;
            s[4]     = s[4] ^ fb;
            s[5]     = s[5] ^ fb;
        end
        r.state = s;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_scr_lane.sv
// +----------------------------------------------------------------------------+
// | pcie_scr_lane: one lane of the scrambler, BYTES symbols chained per pclk  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pcie_scr_lane
    import pcie_scr_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                 pclk,
    input  logic                 reset_n,
    input  logic                 scr_disable_i,
    input  logic                 in_valid_i,
    input  logic [BYTES*8-1:0]   in_data_i,
    input  logic [BYTES-1:0]     in_k_i,
    input  logic [BYTES-1:0]     in_bypass_i,
    output logic [BYTES*8-1:0]   out_data_o,
    output logic [BYTES-1:0]     out_k_o,
    output logic                 out_valid_o
);

    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;
    logic [BYTES*8-1:0] data_q;
    logic [BYTES*8-1:0] data_d;
    logic [BYTES-1:0]   k_q;
    logic               valid_q;

    // Byte 0 is earliest in time; each byte sees the LFSR state left by the previous one
    always_comb begin : p_chain
        logic [15:0] s;
        lfsr_step_t  stp;
        logic [7:0]  din;
        logic        is_com;
        logic        is_skp;
        logic        scramble;
        s        = lfsr_q;
        stp      = '0;
        din      = '0;
        is_com   = 1'b0;
        is_skp   = 1'b0;
        scramble = 1'b0;
        data_d   = '0;
        for (int b = 0; b < BYTES; b++) begin
            din      = in_data_i[b*8 +: 8];
            stp      = lfsr16_step8(s);
            is_com   = in_k_i[b] && (din == K_COM);
            is_skp   = in_k_i[b] && (din == K_SKP);
            scramble = !in_k_i[b] && !in_bypass_i[b] && !scr_disable_i;
            data_d[b*8 +: 8] = scramble ? (din ^ stp.key) : din;
            if (is_com) begin
                s = LFSR_SEED;
            end else if (!is_skp) begin
                s = stp.state;
            end
        end
        lfsr_d = s;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q  <= LFSR_SEED;
            data_q  <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                lfsr_q <= lfsr_d;
                data_q <= data_d;
                k_q    <= in_k_i;
            end
        end
    end

    assign out_data_o  = data_q;
    assign out_k_o     = k_q;
    assign out_valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/pcie_multilane_scrambler.sv
// +----------------------------------------------------------------------------+
// | pcie_multilane_scrambler: LANES independent 8b/10b TX scramblers, lat 1    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pcie_multilane_scrambler
    import pcie_scr_pkg::*;
#(
    parameter int LANES = 4,
    parameter int BYTES = 4
) (
    input  logic                       pclk,
    input  logic                       reset_n,
    input  logic                       scr_disable_i,
    input  logic [LANES-1:0]           in_valid_i,
    input  logic [LANES*BYTES*8-1:0]   in_data_i,
    input  logic [LANES*BYTES-1:0]     in_k_i,
    input  logic [LANES*BYTES-1:0]     in_bypass_i,
    output logic [LANES*BYTES*8-1:0]   out_data_o,
    output logic [LANES*BYTES-1:0]     out_k_o,
    output logic [LANES-1:0]           out_valid_o
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pcie_scr_lane #(
            .BYTES(BYTES)
        ) u_lane (
            .pclk          (pclk),
            .reset_n       (reset_n),
            .scr_disable_i (scr_disable_i),
            .in_valid_i    (in_valid_i[l]),
            .in_data_i     (in_data_i[l*BYTES*8 +: BYTES*8]),
            .in_k_i        (in_k_i[l*BYTES +: BYTES]),
            .in_bypass_i   (in_bypass_i[l*BYTES +: BYTES]),
            .out_data_o    (out_data_o[l*BYTES*8 +: BYTES*8]),
            .out_k_o       (out_k_o[l*BYTES +: BYTES]),
            .out_valid_o   (out_valid_o[l])
        );
    end

endmodule

`default_nettype wire
